// File: rtl/pdm_multi_window.sv
// PDM microphone front end: generates the microphone clock, samples one or two
// channels on opposite clock edges, and counts ones over several overlapping
// windows per channel. Finished window counts queue up in a small
// first-word-fall-through FIFO.
module pdm_multi_window #(
  parameter int CLK_FREQ      = 100,
  parameter int MCLK_FREQ     = 2400000,
  parameter int WINDOW_SIZE   = 200,
  parameter int SAMPLE_WINDOW = 128,
  parameter int NUM_WINDOWS   = 2,
  parameter int STEREO        = 0,
  parameter int FIFO_DEPTH    = 4,
  localparam int AW = $clog2(SAMPLE_WINDOW + 1),
  localparam int WW = (NUM_WINDOWS > 1) ? $clog2(NUM_WINDOWS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  output logic          m_clk,
  output logic          m_clk_en,
  input  logic          m_data,
  output logic [AW-1:0] amp_data,
  output logic          amp_channel,
  output logic [WW-1:0] amp_window,
  output logic          amp_valid,
  input  logic          amp_ready,
  output logic          overflow
);

  localparam int CLK_RAW   = (CLK_FREQ * 1000000) / (MCLK_FREQ * 2);
  localparam int CLK_COUNT = (CLK_RAW < 2) ? 2 : CLK_RAW;
  localparam int CW        = $clog2(CLK_COUNT);
  localparam int NCH       = (STEREO != 0) ? 2 : 1;
  localparam int OFFSET    = WINDOW_SIZE / NUM_WINDOWS;
  localparam int PW        = $clog2(WINDOW_SIZE);
  localparam int FAW       = $clog2(FIFO_DEPTH);
  localparam int EW        = 1 + WW + AW;

  localparam logic [CW-1:0]  CNT_LAST = CW'(CLK_COUNT - 1);
  localparam logic [PW-1:0]  PH_LAST  = PW'(WINDOW_SIZE - 1);
  localparam logic [PW-1:0]  PH_EMIT  = PW'(SAMPLE_WINDOW);
  localparam logic [FAW:0]   FULL_CNT = (FAW + 1)'(FIFO_DEPTH);

  logic [CW-1:0] divCnt_q, divCnt_d;
  logic          mClk_q, mClk_d;
  logic          mClkPrev_q, mClkPrev_d;

  logic [PW-1:0] phase_q  [NCH][NUM_WINDOWS];
  logic [PW-1:0] phase_d  [NCH][NUM_WINDOWS];
  logic [AW-1:0] acc_q    [NCH][NUM_WINDOWS];
  logic [AW-1:0] acc_d    [NCH][NUM_WINDOWS];
  logic          primed_q [NCH][NUM_WINDOWS];
  logic          primed_d [NCH][NUM_WINDOWS];

  logic [EW-1:0] fifoMem_q [FIFO_DEPTH];
  logic [FAW-1:0] rdPtr_q, wrPtr_q;
  logic [FAW:0]  count_q;
  logic          overflow_q;

  logic           riseEn;
  logic [NCH-1:0] chEn;
  logic           push;
  logic [EW-1:0]  pushEntry;
  logic           validInt;
  logic           pop;
  logic           full;
  logic           pushOk;

  // An edge is reported in the first enabled cycle that sees the new m_clk
  // level, so a pause never loses a pending edge.
  assign riseEn = enable & ~rst & mClk_q & ~mClkPrev_q;

  if (NCH == 2) begin : g_stereo
    assign chEn = {enable & ~rst & ~mClk_q & mClkPrev_q, riseEn};
  end else begin : g_mono
    assign chEn = riseEn;
  end

  assign m_clk    = mClk_q & ~rst;
  assign m_clk_en = riseEn;

  // Next-state for the divider and every window's phase, accumulator and priming.
  always_comb begin
    divCnt_d   = divCnt_q;
    mClk_d     = mClk_q;
    mClkPrev_d = mClkPrev_q;
    phase_d    = phase_q;
    acc_d      = acc_q;
    primed_d   = primed_q;
    push       = 1'b0;
    pushEntry  = '0;
    if (enable) begin
      mClkPrev_d = mClk_q;
      if (divCnt_q == CNT_LAST) begin
        divCnt_d = '0;
        mClk_d   = ~mClk_q;
      end else begin
        divCnt_d = divCnt_q + CW'(1);
      end
    end
    for (int c = 0; c < NCH; c++) begin
      for (int k = 0; k < NUM_WINDOWS; k++) begin
        if (chEn[c]) begin
          phase_d[c][k] = (phase_q[c][k] == PH_LAST) ? '0 : phase_q[c][k] + PW'(1);
          if (phase_q[c][k] == '0) begin
            primed_d[c][k] = 1'b1;
          end
          if (phase_q[c][k] < PH_EMIT) begin
            acc_d[c][k] = acc_q[c][k] + AW'(m_data);
          end else if (phase_q[c][k] == PH_EMIT) begin
            acc_d[c][k] = '0;
            if (primed_q[c][k]) begin
              push      = 1'b1;
              pushEntry = {1'(c), WW'(k), acc_q[c][k]};
            end
          end
        end
      end
    end
  end

  // Capture state registers; windows start staggered by OFFSET samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      divCnt_q   <= '0;
      mClk_q     <= 1'b0;
      mClkPrev_q <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        for (int k = 0; k < NUM_WINDOWS; k++) begin
          phase_q[c][k]  <= PW'(k * OFFSET);
          acc_q[c][k]    <= '0;
          primed_q[c][k] <= (k == 0);
        end
      end
    end else begin
      divCnt_q   <= divCnt_d;
      mClk_q     <= mClk_d;
      mClkPrev_q <= mClkPrev_d;
      phase_q    <= phase_d;
      acc_q      <= acc_d;
      primed_q   <= primed_d;
    end
  end

  assign validInt = (count_q != '0) & ~rst;
  assign full     = (count_q == FULL_CNT);
  assign pop      = validInt & amp_ready;
  assign pushOk   = push & (~full | pop);

  // Result FIFO; a push into a full FIFO is only dropped if no pop frees a slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdPtr_q    <= '0;
      wrPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (pushOk) begin
        fifoMem_q[wrPtr_q] <= pushEntry;
        wrPtr_q            <= wrPtr_q + FAW'(1);
      end
      if (pop) begin
        rdPtr_q <= rdPtr_q + FAW'(1);
      end
      if (pushOk && !pop) begin
        count_q <= count_q + (FAW + 1)'(1);
      end else if (!pushOk && pop) begin
        count_q <= count_q - (FAW + 1)'(1);
      end
      if (push && full && !pop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign amp_valid = validInt;
  assign overflow  = overflow_q & ~rst;
  assign {amp_channel, amp_window, amp_data} = validInt ? fifoMem_q[rdPtr_q] : '0;

endmodule

// File: tb/tb_pdm_multi_window.sv
// Scoreboard bench for pdm_multi_window: a sample-index reference model
// predicts every window result and FIFO occupancy; a monitor compares results.
module tb_pdm_multi_window;

  localparam int CLK_FREQ  = 100;
  localparam int MCLK_FREQ = 16000000;
  localparam int W         = 20;
  localparam int S         = 12;
  localparam int NW        = 4;
  localparam int STEREO    = 1;
  localparam int DEPTH     = 4;
  localparam int CC        = 3;
  localparam int OFF       = W / NW;
  localparam int AW        = 4;
  localparam int WW        = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          m_clk;
  logic          m_clk_en;
  logic          m_data = 1'b0;
  logic [AW-1:0] amp_data;
  logic          amp_channel;
  logic [WW-1:0] amp_window;
  logic          amp_valid;
  logic          amp_ready = 1'b1;
  logic          overflow;

  typedef struct packed {
    logic          ch;
    logic [WW-1:0] win;
    logic [AW-1:0] amp;
  } result_t;

  result_t expQ[$];
  bit      hist0[$];
  bit      hist1[$];
  int      vectors = 0;
  int      miscompares = 0;
  int      modelCount = 0;
  int      togCnt = 0;
  int      riseSeen = 0;
  int      popCnt = 0;
  bit      expOvf = 1'b0;
  bit      lastAnyM = 1'b0;
  bit      lastEnM = 1'b0;
  logic    pauseLevel;

  pdm_multi_window #(
    .CLK_FREQ(CLK_FREQ), .MCLK_FREQ(MCLK_FREQ), .WINDOW_SIZE(W),
    .SAMPLE_WINDOW(S), .NUM_WINDOWS(NW), .STEREO(STEREO), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .m_clk(m_clk), .m_clk_en(m_clk_en),
    .m_data(m_data), .amp_data(amp_data), .amp_channel(amp_channel),
    .amp_window(amp_window), .amp_valid(amp_valid), .amp_ready(amp_ready),
    .overflow(overflow)
  );

  // Free-running system clock.
  always #5 clk = ~clk;

  function automatic void check(string name, longint act, longint req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("[TB] FAIL %s: actual %0d, required %0d", name, act, req);
    end
  endfunction

  // Window k is at phase (k*OFF + n) mod W on sample n; it reports the ones in
  // the S samples before each phase-S point, once it has passed a phase-0 point.
  function automatic void takeSample(int ch, bit d, bit popNow);
    int n, p, fz, s;
    result_t r;
    n = (ch == 0) ? hist0.size() : hist1.size();
    for (int k = 0; k < NW; k++) begin
      p  = (k * OFF + n) % W;
      fz = (k == 0) ? 0 : W - k * OFF;
      if (p == S && n - S >= fz) begin
        s = 0;
        for (int j = n - S; j < n; j++) s += (ch == 0) ? int'(hist0[j]) : int'(hist1[j]);
        r.ch  = 1'(ch);
        r.win = WW'(k);
        r.amp = AW'(s);
        if (modelCount == DEPTH && !popNow) expOvf = 1'b1;
        else begin
          expQ.push_back(r);
          modelCount++;
        end
      end
    end
    if (ch == 0) hist0.push_back(d);
    else hist1.push_back(d);
  endfunction

  // Reference model: clock timing, edge pulses, occupancy, overflow, results.
  always @(negedge clk) begin
    bit rise, fall, popNow;
    if (rst) begin
      expQ.delete();
      hist0.delete();
      hist1.delete();
      modelCount = 0;
      expOvf     = 1'b0;
      lastAnyM   = 1'b0;
      lastEnM    = 1'b0;
      togCnt     = 0;
    end else begin
      if (m_clk !== lastAnyM) begin
        check("mclk_half_period", togCnt, CC);
        togCnt = 0;
      end
      if (enable) togCnt++;
      lastAnyM = m_clk;
      rise = enable && m_clk && !lastEnM;
      fall = enable && !m_clk && lastEnM;
      if (enable) lastEnM = m_clk;
      check("m_clk_en", m_clk_en, rise);
      check("amp_valid", amp_valid, modelCount > 0);
      check("overflow", overflow, expOvf);
      popNow = amp_ready && (modelCount > 0);
      if (rise) begin
        riseSeen++;
        takeSample(0, m_data, popNow);
      end
      if (fall && STEREO != 0) takeSample(1, m_data, popNow);
      if (popNow) modelCount--;
    end
  end

  // Monitor: every accepted FIFO head is compared with the scoreboard head.
  always @(negedge clk) begin
    result_t a, e;
    if (!rst && amp_valid && amp_ready) begin
      a = {amp_channel, amp_window, amp_data};
      vectors++;
      if (expQ.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpected_result: actual ch=%0d win=%0d amp=%0d, required no result",
                 a.ch, a.win, a.amp);
      end else begin
        e = expQ.pop_front();
        popCnt++;
        if (a !== e) begin
          miscompares++;
          $display("[TB] FAIL result: actual ch=%0d win=%0d amp=%0d, required ch=%0d win=%0d amp=%0d",
                   a.ch, a.win, a.amp, e.ch, e.win, e.amp);
        end
      end
    end
  end

  task automatic checkOutput(string tag);
    check({tag, "_m_clk"}, m_clk, 0);
    check({tag, "_m_clk_en"}, m_clk_en, 0);
    check({tag, "_amp_valid"}, amp_valid, 0);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_amp_data"}, amp_data, 0);
    check({tag, "_amp_channel"}, amp_channel, 0);
    check({tag, "_amp_window"}, amp_window, 0);
  endtask

  task automatic doReset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checkOutput("in_reset");
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(negedge clk);
    checkOutput("after_reset");
  endtask

  // dataMode: 0 random, 1 all ones, 2 alternating per rise, 3 follows m_clk.
  // readyMode: 0 ready, 1 stalled, 2 random, 3 ready only on rise cycles.
  task automatic applyStimulus(int cycles, int dataMode, int readyMode);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      case (dataMode)
        0:       m_data = 1'($urandom);
        1:       m_data = 1'b1;
        2:       m_data = ~riseSeen[0];
        default: m_data = m_clk;
      endcase
      case (readyMode)
        0:       amp_ready = 1'b1;
        1:       amp_ready = 1'b0;
        2:       amp_ready = 1'($urandom);
        default: begin
          #1;
          amp_ready = m_clk_en;
        end
      endcase
    end
  endtask

  initial begin
    int waitCnt;
    doReset();
    enable = 1'b1;
    applyStimulus(600, 1, 0);
    applyStimulus(600, 2, 0);
    applyStimulus(600, 3, 0);
    applyStimulus(1500, 0, 2);

    applyStimulus(800, 0, 1);
    check("overflow_after_stall", overflow, 1);
    applyStimulus(600, 0, 3);
    applyStimulus(400, 0, 0);

    applyStimulus(100, 0, 0);
    enable = 1'b0;
    pauseLevel = m_clk;
    applyStimulus(1000, 0, 0);
    check("pause_m_clk_frozen", m_clk, pauseLevel);
    check("pause_fifo_drained", amp_valid, 0);
    enable = 1'b1;
    applyStimulus(400, 0, 2);

    applyStimulus(37, 1, 1);
    doReset();
    applyStimulus(600, 0, 0);

    enable = 1'b0;
    amp_ready = 1'b1;
    waitCnt = 0;
    while (expQ.size() > 0 && waitCnt < 200) begin
      @(posedge clk);
      waitCnt++;
    end
    @(negedge clk);
    check("drain_empty", expQ.size(), 0);
    check("results_seen_min", popCnt >= 40, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: actual timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
